// File: rtl/mem4x4_pkg.sv
// Shared encodings and sizes for the 4-word x 4-bit memory access controller.
package mem4x4_pkg;

    localparam int AW    = 2;
    localparam int DW    = 4;
    localparam int DEPTH = 4;

    typedef enum logic [1:0] {
        OP_WRITE    = 2'b00,
        OP_READ     = 2'b01,
        OP_FILL     = 2'b10,
        OP_BURST_RD = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        FILL,
        BURST_RD
    } state_e;

endpackage

// File: rtl/mem4x4_access_ctrl.sv
// Sequencer driving the register-file memory pins from registers and returning
// read data through a single back-pressured response slot.
module mem4x4_access_ctrl
    import mem4x4_pkg::*;
(
    input  logic          CLK,
    input  logic          RST,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_data,
    output logic          mem_rw,
    output logic [AW-1:0] mem_ad,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic [AW-1:0] rsp_addr,
    output logic          rsp_last,
    output logic          busy
);

    state_e        state_q, state_d;
    logic          mem_rw_q, mem_rw_d;
    logic [AW-1:0] mem_ad_q, mem_ad_d;
    logic [DW-1:0] mem_din_q, mem_din_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic [AW-1:0] rsp_addr_q, rsp_addr_d;
    logic          rsp_last_q, rsp_last_d;
    logic [1:0]    beat_q, beat_d;
    logic          slot_free;
    logic          capture;

    assign cmd_ready = (state_q == IDLE) && !RST;
    assign busy      = (state_q != IDLE);
    assign slot_free = !rsp_valid_q || rsp_ready;

    always_comb begin
        state_d     = state_q;
        mem_rw_d    = mem_rw_q;
        mem_ad_d    = mem_ad_q;
        mem_din_d   = mem_din_q;
        rsp_valid_d = rsp_valid_q && !rsp_ready;
        rsp_data_d  = rsp_data_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_last_d  = rsp_last_q;
        beat_d      = beat_q;
        capture     = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    mem_ad_d  = cmd_addr;
                    mem_din_d = cmd_data;
                    beat_d    = '0;
                    mem_rw_d  = 1'b0;
                    case (op_e'(cmd_op))
                        OP_WRITE: begin
                            state_d  = WRITE;
                            mem_rw_d = 1'b1;
                        end
                        OP_READ:  state_d = READ;
                        OP_FILL: begin
                            state_d  = FILL;
                            mem_rw_d = 1'b1;
                            mem_ad_d = '0;
                        end
                        OP_BURST_RD: state_d = BURST_RD;
                    endcase
                end
            end
            WRITE: begin
                state_d  = IDLE;
                mem_rw_d = 1'b0;
            end
            READ: begin
                if (slot_free) begin
                    capture    = 1'b1;
                    rsp_last_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            FILL: begin
                if (beat_q == 2'd3) begin
                    state_d  = IDLE;
                    mem_rw_d = 1'b0;
                end else begin
                    beat_d   = beat_q + 2'd1;
                    mem_ad_d = mem_ad_q + AW'(1);
                end
            end
            BURST_RD: begin
                // Address and beat count only move on capture so a stall freezes mem_ad.
                if (slot_free) begin
                    capture    = 1'b1;
                    rsp_last_d = (beat_q == 2'd3);
                    if (beat_q == 2'd3) begin
                        state_d = IDLE;
                    end else begin
                        beat_d   = beat_q + 2'd1;
                        mem_ad_d = mem_ad_q + AW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = mem_dout;
            rsp_addr_d  = mem_ad_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            mem_rw_q    <= 1'b0;
            mem_ad_q    <= '0;
            mem_din_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_addr_q  <= '0;
            rsp_last_q  <= 1'b0;
            beat_q      <= '0;
        end else begin
            state_q     <= state_d;
            mem_rw_q    <= mem_rw_d;
            mem_ad_q    <= mem_ad_d;
            mem_din_q   <= mem_din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_last_q  <= rsp_last_d;
            beat_q      <= beat_d;
        end
    end

    assign mem_rw    = mem_rw_q;
    assign mem_ad    = mem_ad_q;
    assign mem_din   = mem_din_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_last  = rsp_last_q;

endmodule

// File: tb/tb_mem4x4_access_ctrl.sv
// Directed bench for mem4x4_access_ctrl with a behavioural 4x4 register-file memory attached.
module tb_mem4x4_access_ctrl;
    import mem4x4_pkg::*;

    logic          CLK = 1'b0;
    logic          RST;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic          mem_rw;
    logic [AW-1:0] mem_ad;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] rsp_addr;
    logic          rsp_last;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [DEPTH];

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
        end else if (mem_rw) begin
            mem[mem_ad] <= mem_din;
        end
    end
    assign mem_dout = mem[mem_ad];

    mem4x4_access_ctrl dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .mem_rw(mem_rw), .mem_ad(mem_ad), .mem_din(mem_din), .mem_dout(mem_dout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_addr(rsp_addr), .rsp_last(rsp_last), .busy(busy)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Offers a command, waits (bounded) for cmd_ready and returns just after the accepting edge.
    task automatic send_cmd(input logic [1:0] op, input logic [1:0] addr, input logic [3:0] data);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL cmd_accept_timeout: cmd_ready=%b want 1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
        checks++; if (mem_rw !== 1'b0) begin errors++; $display("[TB] FAIL rst_mem_rw: got %b want 0", mem_rw); end
        checks++; if (mem_ad !== 2'd0) begin errors++; $display("[TB] FAIL rst_mem_ad: got %0d want 0", mem_ad); end
        checks++; if (mem_din !== 4'h0) begin errors++; $display("[TB] FAIL rst_mem_din: got %h want 0", mem_din); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_data !== 4'h0) begin errors++; $display("[TB] FAIL rst_rsp_data: got %h want 0", rsp_data); end
        checks++; if (rsp_addr !== 2'd0) begin errors++; $display("[TB] FAIL rst_rsp_addr: got %0d want 0", rsp_addr); end
        checks++; if (rsp_last !== 1'b0) begin errors++; $display("[TB] FAIL rst_rsp_last: got %b want 0", rsp_last); end
        RST = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_write_read();
        rsp_ready = 1'b1;
        send_cmd(OP_WRITE, 2'd2, 4'hA);
        checks++; if (mem_rw !== 1'b1) begin errors++; $display("[TB] FAIL wr_rw: got %b want 1", mem_rw); end
        checks++; if (mem_ad !== 2'd2) begin errors++; $display("[TB] FAIL wr_ad: got %0d want 2", mem_ad); end
        checks++; if (mem_din !== 4'hA) begin errors++; $display("[TB] FAIL wr_din: got %h want a", mem_din); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL wr_busy: got %b want 1", busy); end
        tick();
        checks++; if (mem_rw !== 1'b0) begin errors++; $display("[TB] FAIL wr_rw_drop: got %b want 0", mem_rw); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL wr_busy_drop: got %b want 0", busy); end
        send_cmd(OP_READ, 2'd2, 4'h0);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rd_early_valid: got %b want 0", rsp_valid); end
        checks++; if (mem_rw !== 1'b0) begin errors++; $display("[TB] FAIL rd_rw: got %b want 0", mem_rw); end
        tick();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL rd_valid: got %b want 1", rsp_valid); end
        checks++; if (rsp_data !== 4'hA) begin errors++; $display("[TB] FAIL rd_data: got %h want a", rsp_data); end
        checks++; if (rsp_addr !== 2'd2) begin errors++; $display("[TB] FAIL rd_addr: got %0d want 2", rsp_addr); end
        checks++; if (rsp_last !== 1'b1) begin errors++; $display("[TB] FAIL rd_last: got %b want 1", rsp_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rd_busy: got %b want 0", busy); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rd_consumed: got %b want 0", rsp_valid); end
    endtask

    task automatic test_fill_burst();
        rsp_ready = 1'b1;
        send_cmd(OP_FILL, 2'd3, 4'h5);
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem_rw !== 1'b1) begin errors++; $display("[TB] FAIL fill_rw[%0d]: got %b want 1", i, mem_rw); end
            checks++; if (mem_ad !== 2'(i)) begin errors++; $display("[TB] FAIL fill_ad[%0d]: got %0d want %0d", i, mem_ad, i); end
            checks++; if (mem_din !== 4'h5) begin errors++; $display("[TB] FAIL fill_din[%0d]: got %h want 5", i, mem_din); end
            tick();
        end
        checks++; if (mem_rw !== 1'b0) begin errors++; $display("[TB] FAIL fill_rw_end: got %b want 0", mem_rw); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL fill_busy_end: got %b want 0", busy); end
        send_cmd(OP_BURST_RD, 2'd0, 4'h0);
        for (int b = 0; b < 4; b++) begin
            tick();
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL fb_valid[%0d]: got %b want 1", b, rsp_valid); end
            checks++; if (rsp_data !== 4'h5) begin errors++; $display("[TB] FAIL fb_data[%0d]: got %h want 5", b, rsp_data); end
            checks++; if (rsp_addr !== 2'(b)) begin errors++; $display("[TB] FAIL fb_addr[%0d]: got %0d want %0d", b, rsp_addr, b); end
            checks++; if (rsp_last !== (b == 3)) begin errors++; $display("[TB] FAIL fb_last[%0d]: got %b want %b", b, rsp_last, (b == 3)); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL fb_busy_end: got %b want 0", busy); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL fb_drained: got %b want 0", rsp_valid); end
    endtask

    task automatic test_burst_wrap();
        logic [1:0] exp_a [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
        logic [3:0] exp_d [4] = '{4'h3, 4'h4, 4'h1, 4'h2};
        rsp_ready = 1'b1;
        for (int a = 0; a < 4; a++) begin
            send_cmd(OP_WRITE, 2'(a), 4'(a + 1));
            tick();
        end
        send_cmd(OP_BURST_RD, 2'd2, 4'h0);
        for (int b = 0; b < 4; b++) begin
            tick();
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL wrap_valid[%0d]: got %b want 1", b, rsp_valid); end
            checks++; if (rsp_addr !== exp_a[b]) begin errors++; $display("[TB] FAIL wrap_addr[%0d]: got %0d want %0d", b, rsp_addr, exp_a[b]); end
            checks++; if (rsp_data !== exp_d[b]) begin errors++; $display("[TB] FAIL wrap_data[%0d]: got %h want %h", b, rsp_data, exp_d[b]); end
        end
        tick();
    endtask

    task automatic test_back_pressure();
        logic [1:0] exp_a [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        logic [3:0] exp_d [4] = '{4'h2, 4'h3, 4'h4, 4'h1};
        rsp_ready = 1'b1;
        send_cmd(OP_BURST_RD, 2'd1, 4'h0);
        tick();
        rsp_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid[%0d]: got %b want 1", s, rsp_valid); end
            checks++; if (rsp_addr !== exp_a[0]) begin errors++; $display("[TB] FAIL bp_addr[%0d]: got %0d want %0d", s, rsp_addr, exp_a[0]); end
            checks++; if (rsp_data !== exp_d[0]) begin errors++; $display("[TB] FAIL bp_data[%0d]: got %h want %h", s, rsp_data, exp_d[0]); end
            checks++; if (mem_ad !== 2'd2) begin errors++; $display("[TB] FAIL bp_mem_ad[%0d]: got %0d want 2", s, mem_ad); end
            checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL bp_busy[%0d]: got %b want 1", s, busy); end
            tick();
        end
        checks++; if (rsp_data !== exp_d[0]) begin errors++; $display("[TB] FAIL bp_hold_end: got %h want %h", rsp_data, exp_d[0]); end
        rsp_ready = 1'b1;
        for (int b = 1; b < 4; b++) begin
            tick();
            checks++; if (rsp_addr !== exp_a[b]) begin errors++; $display("[TB] FAIL bp_beat_addr[%0d]: got %0d want %0d", b, rsp_addr, exp_a[b]); end
            checks++; if (rsp_data !== exp_d[b]) begin errors++; $display("[TB] FAIL bp_beat_data[%0d]: got %h want %h", b, rsp_data, exp_d[b]); end
            checks++; if (rsp_last !== (b == 3)) begin errors++; $display("[TB] FAIL bp_beat_last[%0d]: got %b want %b", b, rsp_last, (b == 3)); end
        end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        rsp_ready = 1'b1;
        send_cmd(OP_BURST_RD, 2'd0, 4'h0);
        tick();
        checks++; if (rsp_data !== 4'h1) begin errors++; $display("[TB] FAIL mr_beat1: got %h want 1", rsp_data); end
        RST = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mr_busy: got %b want 0", busy); end
        checks++; if (mem_ad !== 2'd0) begin errors++; $display("[TB] FAIL mr_mem_ad: got %0d want 0", mem_ad); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL mr_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_data !== 4'h0) begin errors++; $display("[TB] FAIL mr_rsp_data: got %h want 0", rsp_data); end
        checks++; if (rsp_last !== 1'b0) begin errors++; $display("[TB] FAIL mr_rsp_last: got %b want 0", rsp_last); end
        RST = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL mr_cmd_ready: got %b want 1", cmd_ready); end
        send_cmd(OP_READ, 2'd3, 4'h0);
        tick();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL mr_read_valid: got %b want 1", rsp_valid); end
        checks++; if (rsp_data !== 4'h0) begin errors++; $display("[TB] FAIL mr_read_data: got %h want 0", rsp_data); end
        checks++; if (rsp_addr !== 2'd3) begin errors++; $display("[TB] FAIL mr_read_addr: got %0d want 3", rsp_addr); end
        tick();
    endtask

    task automatic test_back_to_back();
        rsp_ready = 1'b1;
        send_cmd(OP_FILL, 2'd0, 4'h9);
        cmd_valid = 1'b1;
        cmd_op    = OP_WRITE;
        cmd_addr  = 2'd1;
        cmd_data  = 4'hC;
        for (int i = 0; i < 4; i++) begin
            checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready[%0d]: got %b want 0", i, cmd_ready); end
            checks++; if (mem_din !== 4'h9) begin errors++; $display("[TB] FAIL b2b_fill_din[%0d]: got %h want 9", i, mem_din); end
            tick();
        end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_idle_ready: got %b want 1", cmd_ready); end
        tick();
        cmd_valid = 1'b0;
        checks++; if (mem_rw !== 1'b1) begin errors++; $display("[TB] FAIL b2b_wr_rw: got %b want 1", mem_rw); end
        checks++; if (mem_ad !== 2'd1) begin errors++; $display("[TB] FAIL b2b_wr_ad: got %0d want 1", mem_ad); end
        checks++; if (mem_din !== 4'hC) begin errors++; $display("[TB] FAIL b2b_wr_din: got %h want c", mem_din); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (mem_rw !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_once[%0d]: rw=%b busy=%b want 0 0", i, mem_rw, busy); end
        end
        send_cmd(OP_BURST_RD, 2'd0, 4'h0);
        for (int b = 0; b < 4; b++) begin
            tick();
            checks++; if (rsp_data !== ((b == 1) ? 4'hC : 4'h9)) begin errors++; $display("[TB] FAIL b2b_data[%0d]: got %h want %h", b, rsp_data, ((b == 1) ? 4'hC : 4'h9)); end
        end
        tick();
    endtask

    initial begin
        RST       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_addr  = '0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_write_read();
        test_fill_burst();
        test_burst_wrap();
        test_back_pressure();
        test_reset_mid_burst();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "[TB] timeout");
    end

endmodule
